// File: rtl/sr_switch_debounce_pkg.sv
// Shared helpers for the console switch debouncer.
package sr_switch_debounce_pkg;

  // Qualification counter width; a single-tick window still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: qualifies a new synchronised level over STABLE_TICKS sample ticks.
module debounce_bit
  import sr_switch_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  input  logic tick,
  input  logic bypass,
  output logic level,
  output logic flip
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      flip  <= 1'b0;
    end else begin
      flip <= 1'b0;
      if (bypass) begin
        cnt   <= '0;
        level <= sync_in;
        flip  <= (sync_in != level);
      end else if (sync_in == level) begin
        // Any return to the current level discards partial qualification.
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          level <= sync_in;
          flip  <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sr_switch_debounce.sv
// Front-panel switch front end: per-bit sync + debounce, shared sample prescaler,
// and a single changed pulse when any debounced bit flips.
module sr_switch_debounce #(
  parameter int WIDTH        = 16,
  parameter int CLK_DIV      = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_sw,
  input  logic             bypass,
  output logic [WIDTH-1:0] switches,
  output logic             changed,
  output logic             tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_TICK = PW'(CLK_DIV - 2);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] flips;
  logic [PW-1:0]    pre_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw_sw;
      sync_q    <= sync_meta;
    end
  end

  // tick is registered one count early so it is high while pre_cnt == CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      if (pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + 1'b1;
      tick <= (pre_cnt == PRE_TICK);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |flips;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .sync_in(sync_q[i]),
      .tick   (tick),
      .bypass (bypass),
      .level  (switches[i]),
      .flip   (flips[i])
    );
  end

endmodule
